// File: rtl/usb_ep_loopback_backend.sv
// Endpoint loopback backend: drains one committed EP_IN transaction into a local buffer and
// echoes it into EP_OUT. Optional output byte transform enabled by USB_EP_LOOPBACK_XOR_EN.
module usb_ep_loopback_backend #(
  parameter int unsigned BUF_DEPTH    = 64,
  parameter int unsigned FULL_TIMEOUT = 1024,
  parameter logic [7:0]  XOR_MASK     = 8'h00
) (
  input  logic        clk12_i,
  input  logic        rst_i,
  input  logic        EP_IN_dataAvailable_i,
  input  logic [7:0]  EP_IN_data_i,
  output logic        EP_IN_popData_o,
  output logic        EP_IN_popTransDone_o,
  output logic        EP_IN_popTransSuccess_o,
  input  logic        EP_OUT_full_i,
  output logic        EP_OUT_dataValid_o,
  output logic [7:0]  EP_OUT_data_o,
  output logic        EP_OUT_fillTransDone_o,
  output logic        EP_OUT_fillTransSuccess_o,
  output logic        busy_o,
  output logic [15:0] echoCount_o
);

  localparam int unsigned IW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned SW = $clog2(FULL_TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(BUF_DEPTH);
  localparam logic [SW-1:0] TIMEOUT_C = SW'(FULL_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StCapCommit,
    StEcho,
    StEchoCommit,
    StAbort
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] rd_q;
  logic [SW-1:0] stall_q;
  logic [15:0]   echo_cnt_q;
  logic          pop_done_q;
  logic          fill_done_q;
  logic          fill_ok_q;
  logic [7:0]    buf_q [BUF_DEPTH];

  logic          pop;
  logic [7:0]    rd_byte;

  assign pop     = (state_q == StCapture) && EP_IN_dataAvailable_i && (cnt_q < DEPTH_C);
  assign rd_byte = buf_q[rd_q[IW-1:0]];

  // Buffer holds raw bytes; no reset needed since reads only follow writes.
  always_ff @(posedge clk12_i) begin
    if (pop) begin
      buf_q[cnt_q[IW-1:0]] <= EP_IN_data_i;
    end
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_q        <= '0;
      stall_q     <= '0;
      echo_cnt_q  <= '0;
      pop_done_q  <= 1'b0;
      fill_done_q <= 1'b0;
      fill_ok_q   <= 1'b0;
    end else begin
      pop_done_q  <= 1'b0;
      fill_done_q <= 1'b0;
      fill_ok_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (EP_IN_dataAvailable_i) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (pop) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (!EP_IN_dataAvailable_i || (cnt_q == DEPTH_C)) begin
            state_q    <= StCapCommit;
            pop_done_q <= 1'b1;
          end
        end
        StCapCommit: begin
          rd_q    <= '0;
          stall_q <= '0;
          // An empty capture has nothing to echo.
          state_q <= (cnt_q == '0) ? StIdle : StEcho;
        end
        StEcho: begin
          if (!EP_OUT_full_i) begin
            stall_q <= '0;
            rd_q    <= rd_q + 1'b1;
            if (rd_q == (cnt_q - 1'b1)) begin
              state_q     <= StEchoCommit;
              fill_done_q <= 1'b1;
              fill_ok_q   <= 1'b1;
              echo_cnt_q  <= echo_cnt_q + 1'b1;
            end
          end else if (stall_q == (TIMEOUT_C - 1'b1)) begin
            state_q     <= StAbort;
            fill_done_q <= 1'b1;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        StEchoCommit, StAbort: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    EP_OUT_data_o = 8'h00;
    if (state_q == StEcho) begin
`ifdef USB_EP_LOOPBACK_XOR_EN
      EP_OUT_data_o = rd_byte ^ XOR_MASK;
`else
      EP_OUT_data_o = rd_byte;
`endif
    end
  end

`ifndef USB_EP_LOOPBACK_XOR_EN
  logic unused_xor_mask;
  assign unused_xor_mask = ^XOR_MASK;
`endif

  assign EP_IN_popData_o           = pop;
  assign EP_IN_popTransDone_o      = pop_done_q;
  assign EP_IN_popTransSuccess_o   = pop_done_q;
  assign EP_OUT_dataValid_o        = (state_q == StEcho);
  assign EP_OUT_fillTransDone_o    = fill_done_q;
  assign EP_OUT_fillTransSuccess_o = fill_ok_q;
  assign busy_o                    = (state_q != StIdle);
  assign echoCount_o               = echo_cnt_q;

endmodule

// File: tb/tb_usb_ep_loopback_backend.sv
// Bench for usb_ep_loopback_backend: queue-based EP_IN FIFO, transaction-level echo model and
// per-cycle contract checks, plus literal expectations for each directed scenario.
module tb_usb_ep_loopback_backend;

  localparam int unsigned BD = 64;
  localparam int unsigned FT = 16;
`ifdef USB_EP_LOOPBACK_XOR_EN
  localparam logic [7:0] MASK = 8'hFF;
`else
  localparam logic [7:0] MASK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        avail = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        pop_o, pop_done, pop_succ;
  logic        full = 1'b0;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        fill_done, fill_succ, busy;
  logic [15:0] echo_o;

  always #5 clk = ~clk;

  usb_ep_loopback_backend #(
    .BUF_DEPTH   (BD),
    .FULL_TIMEOUT(FT),
    .XOR_MASK    (8'hFF)
  ) dut (
    .clk12_i                  (clk),
    .rst_i                    (rst),
    .EP_IN_dataAvailable_i    (avail),
    .EP_IN_data_i             (in_data),
    .EP_IN_popData_o          (pop_o),
    .EP_IN_popTransDone_o     (pop_done),
    .EP_IN_popTransSuccess_o  (pop_succ),
    .EP_OUT_full_i            (full),
    .EP_OUT_dataValid_o       (valid_o),
    .EP_OUT_data_o            (data_o),
    .EP_OUT_fillTransDone_o   (fill_done),
    .EP_OUT_fillTransSuccess_o(fill_succ),
    .busy_o                   (busy),
    .echoCount_o              (echo_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // EP_IN FIFO model (first-word fall-through)
  logic [7:0] in_q[$];
  logic [7:0] stage[$];
  bit         pop_seen = 1'b0;

  always @(posedge clk) begin
    #1;
    if (pop_seen && in_q.size() > 0) void'(in_q.pop_front());
    avail   = (in_q.size() != 0);
    in_data = avail ? in_q[0] : 8'h00;
  end

  // Transaction-level echo model
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  int         cap_len[$];
  logic [7:0] got_log[$];
  bit         expect_abort = 1'b0;
  int         cur_bytes = 0;
  int         popped = 0;
  int         exp_echo = 0;
  int         stall_run = 0;
  int         abort_stall = -1;
  int         fill_done_cnt = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    pop_seen = pop_o && avail;
    if (rst) begin
      exp_bytes.delete();
      exp_len.delete();
      cap_len.delete();
      cur_bytes = 0;
      popped    = 0;
      exp_echo  = 0;
      stall_run = 0;
      prev_hold = 1'b0;
    end else begin
      chk("pop_success_qualified", int'(pop_succ && !pop_done), 0);
      chk("fill_success_qualified", int'(fill_succ && !fill_done), 0);
      if (valid_o || pop_done || fill_done) chk("busy_active", int'(busy), 1);
      if (pop_seen) popped++;
      if (avail && !pop_o && popped > 0 && popped < BD && !pop_done) chk("pop_gap", 1, 0);
      if (pop_done) begin
        chk("pop_success", int'(pop_succ), 1);
        chk("capture_len", popped, (cap_len.size() > 0) ? cap_len.pop_front() : -1);
        popped = 0;
      end
      if (fill_done) begin
        fill_done_cnt++;
        if (expect_abort) begin
          chk("abort_success", int'(fill_succ), 0);
          chk("abort_stall_cycles", stall_run, FT);
          chk("abort_bytes", cur_bytes, 0);
          abort_stall = stall_run;
        end else begin
          chk("commit_success", int'(fill_succ), 1);
          chk("echo_len", cur_bytes, (exp_len.size() > 0) ? exp_len.pop_front() : -1);
          exp_echo = (exp_echo + 1) % 65536;
        end
        cur_bytes = 0;
      end
      if (prev_hold && valid_o) chk("hold_stable", int'(data_o), int'(prev_data));
      if (valid_o && !full) begin
        if (exp_bytes.size() == 0) chk("unexpected_byte", 1, 0);
        else chk("echo_byte", int'(data_o), int'(exp_bytes.pop_front()));
        got_log.push_back(data_o);
        cur_bytes++;
        stall_run = 0;
      end else if (valid_o && full) begin
        stall_run++;
      end else begin
        stall_run = 0;
      end
      prev_hold = valid_o && full;
      prev_data = data_o;
      chk("echo_count", int'(echo_o), exp_echo);
    end
  end

  // Load stage[] into the FIFO and split it into BD-sized expected echoes.
  task automatic send(input bit abort);
    int n;
    @(posedge clk);
    #2;
    n = stage.size();
    for (int off = 0; off < n; off += BD) begin
      int len = (n - off > BD) ? BD : n - off;
      cap_len.push_back(len);
      if (!abort) exp_len.push_back(len);
      for (int j = off; j < off + len; j++) begin
        if (!abort) exp_bytes.push_back(stage[j] ^ MASK);
      end
    end
    for (int i = 0; i < n; i++) in_q.push_back(stage[i]);
  endtask

  task automatic wait_fills(input int target, input int budget);
    for (int i = 0; i < budget && fill_done_cnt < target; i++) @(posedge clk);
    chk("fill_within_budget", int'(fill_done_cnt >= target), 1);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    for (int i = 0; i < budget && got_log.size() < target; i++) @(posedge clk);
    chk("bytes_within_budget", int'(got_log.size() >= target), 1);
  endtask

  task automatic check_idle_zero(input string name);
    chk(name, int'({pop_o, pop_done, pop_succ, valid_o, data_o, fill_done, fill_succ, busy,
                    echo_o}), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset_outputs");
    rst = 1'b0;

    // 3-byte round trip
    got_log.delete();
    stage = '{8'h11, 8'h22, 8'h33};
    send(1'b0);
    wait_fills(1, 200);
    wait_bytes(3, 10);
    chk("t1_b0", int'(got_log[0]), int'(8'h11 ^ MASK));
    chk("t1_b2", int'(got_log[2]), int'(8'h33 ^ MASK));
    chk("t1_echo_count", int'(echo_o), 1);

    // Back-pressure for 5 cycles after the first byte
    got_log.delete();
    send(1'b0);
    wait_bytes(1, 200);
    #1 full = 1'b1;
    repeat (5) @(posedge clk);
    #1 full = 1'b0;
    wait_fills(2, 200);
    wait_bytes(3, 10);
    chk("t2_b1", int'(got_log[1]), int'(8'h22 ^ MASK));
    chk("t2_echo_count", int'(echo_o), 2);

    // Overlong transaction splits at BD
    got_log.delete();
    stage.delete();
    for (int i = 0; i < 70; i++) stage.push_back(8'(i));
    send(1'b0);
    wait_fills(4, 1000);
    wait_bytes(70, 10);
    chk("t3_b63", int'(got_log[63]), int'(8'd63 ^ MASK));
    chk("t3_b64", int'(got_log[64]), int'(8'd64 ^ MASK));
    chk("t3_echo_count", int'(echo_o), 4);

    // Stuck full: abort after FT stalls
    @(posedge clk);
    #1 full = 1'b1;
    expect_abort = 1'b1;
    got_log.delete();
    stage = '{8'hC1, 8'hC2};
    send(1'b1);
    wait_fills(5, 200);
    @(posedge clk);
    #1;
    chk("t4_abort_stall", abort_stall, 16);
    chk("t4_echo_count", int'(echo_o), 4);
    @(posedge clk);
    #1;
    chk("t4_idle", int'(busy), 0);
    chk("t4_no_bytes", got_log.size(), 0);
    full = 1'b0;
    expect_abort = 1'b0;

    // Reset in the middle of an echo
    got_log.delete();
    stage = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    send(1'b0);
    wait_bytes(2, 200);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_zero("t5_reset_outputs");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_done", int'({pop_done, fill_done}), 0);
    end
    got_log.delete();
    stage = '{8'h7E};
    send(1'b0);
    wait_fills(fill_done_cnt + 1, 200);
    wait_bytes(1, 10);
    chk("t5_byte", int'(got_log[0]), int'(8'h7E ^ MASK));
    chk("t5_echo_count", int'(echo_o), 1);

    // Transform case
    got_log.delete();
    stage = '{8'hA5, 8'h00};
    send(1'b0);
    wait_fills(fill_done_cnt + 1, 200);
    wait_bytes(2, 10);
`ifdef USB_EP_LOOPBACK_XOR_EN
    chk("t6_b0", int'(got_log[0]), 8'h5A);
    chk("t6_b1", int'(got_log[1]), 8'hFF);
`else
    chk("t6_b0", int'(got_log[0]), 8'hA5);
    chk("t6_b1", int'(got_log[1]), 8'h00);
`endif
    chk("t6_echo_count", int'(echo_o), 2);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
